miner_job_feeder: RTL and testbench

- Host-side driver for the mining core's word-serial job interface.
- Accepts one job (256-bit midstate plus 512-bit header block), signals a job start, and streams the job as 32-bit words with a per-word shift strobe.
- Waits for the core to claim a solution, captures the 32-bit golden nonce, acknowledges the claim, and reports the result upstream.
- Also gives up after a programmable timeout.

---
 rtl/miner_job_feeder_if.sv | 60 ++++++
 rtl/miner_job_feeder.sv | 151 +++++++++++++++
 tb/tb_miner_job_feeder.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miner_job_feeder_if.sv
// Job/core/result signal bundle for miner_job_feeder.
// master = the feeder itself, slave = host plus mining core.
interface miner_job_feeder_if;

  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_midstate;
  logic [511:0] job_header;
  logic         abort;

  logic         start_found;
  logic         shift_in_enable;
  logic [31:0]  out_word;

  logic         sol_claim;
  logic [31:0]  sol_nonce;
  logic         sol_response;

  logic         result_valid;
  logic         result_ready;
  logic         result_found;
  logic [31:0]  result_nonce;

  modport master (
    input  job_valid,
    input  job_midstate,
    input  job_header,
    input  abort,
    input  sol_claim,
    input  sol_nonce,
    input  result_ready,
    output job_ready,
    output start_found,
    output shift_in_enable,
    output out_word,
    output sol_response,
    output result_valid,
    output result_found,
    output result_nonce
  );

  modport slave (
    output job_valid,
    output job_midstate,
    output job_header,
    output abort,
    output sol_claim,
    output sol_nonce,
    output result_ready,
    input  job_ready,
    input  start_found,
    input  shift_in_enable,
    input  out_word,
    input  sol_response,
    input  result_valid,
    input  result_found,
    input  result_nonce
  );

endinterface

// File: rtl/miner_job_feeder.sv
// Streams one mining job to the core word by word, waits for a
// golden nonce or a timeout, and reports the outcome upstream.
module miner_job_feeder #(
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 16777216,
  parameter int unsigned TMR_W          = 32
) (
  input  logic                clk,
  input  logic                rst,
  miner_job_feeder_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND_MID,
    SEND_HEAD,
    WAIT_SOL,
    ACK,
    REPORT
  } state_t;

  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYCLES);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]       LAST_MID = 5'd7;
  localparam logic [4:0]       LAST_WRD = 5'd23;

  state_t           state_q, state_d;
  // midstate then header, shifted left one word per strobe
  logic [767:0]     job_q, job_d;
  logic [4:0]       idx_q, idx_d;
  // gap countdown while sending, timeout count-up while waiting
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             found_q, found_d;
  logic [31:0]      nonce_q, nonce_d;

  logic sending;
  logic strobe;
  logic abort_hit;
  logic in_report;

  // Decode of the current state shared by next-state and outputs.
  always_comb begin
    sending   = (state_q == SEND_MID) || (state_q == SEND_HEAD);
    strobe    = sending && (tmr_q == '0);
    in_report = (state_q == REPORT);
    abort_hit = bus.abort && (state_q != IDLE) && !in_report;
  end

  // Next-state and datapath update; abort overrides everything.
  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    found_d = found_q;
    nonce_d = nonce_q;
    unique case (state_q)
      IDLE: begin
        if (bus.job_valid) begin
          job_d   = {bus.job_midstate, bus.job_header};
          idx_d   = '0;
          tmr_d   = '0;
          found_d = 1'b0;
          nonce_d = '0;
          state_d = START;
        end
      end
      START: begin
        state_d = SEND_MID;
      end
      SEND_MID, SEND_HEAD: begin
        if (strobe) begin
          job_d = {job_q[735:0], 32'h0};
          if (idx_q == LAST_WRD) begin
            tmr_d   = '0;
            state_d = WAIT_SOL;
          end else begin
            idx_d = idx_q + 5'd1;
            tmr_d = GAP_LD;
            if (idx_q == LAST_MID) begin
              state_d = SEND_HEAD;
            end
          end
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      WAIT_SOL: begin
        if (bus.sol_claim) begin
          nonce_d = bus.sol_nonce;
          found_d = 1'b1;
          state_d = ACK;
        end else if (tmr_q == TMO_LAST) begin
          nonce_d = '0;
          found_d = 1'b0;
          state_d = REPORT;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      ACK: begin
        state_d = REPORT;
      end
      REPORT: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      idx_d   = '0;
      tmr_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      job_q   <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      found_q <= 1'b0;
      nonce_q <= '0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      found_q <= found_d;
      nonce_q <= nonce_d;
    end
  end

  // Strobes drop in the same cycle an abort is seen.
  assign bus.job_ready       = (state_q == IDLE);
  assign bus.start_found     = (state_q == START) && !abort_hit;
  assign bus.shift_in_enable = strobe && !abort_hit;
  assign bus.out_word        = bus.shift_in_enable ? job_q[767:736] : 32'h0;
  assign bus.sol_response    = (state_q == ACK) && !abort_hit;
  assign bus.result_valid    = in_report;
  assign bus.result_found    = in_report && found_q;
  assign bus.result_nonce    = (in_report && found_q) ? nonce_q : 32'h0;

endmodule

// File: tb/tb_miner_job_feeder.sv
// Randomized self-checking bench for miner_job_feeder.
// Two instances: one with no word gap, one with a 2-cycle gap.
module tb_miner_job_feeder;

  localparam int TMO = 10;
  localparam int NW  = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  logic         job_valid = 1'b0;
  logic         abort_i   = 1'b0;
  logic         claim     = 1'b0;
  logic         ready     = 1'b0;
  logic [255:0] mid       = '0;
  logic [511:0] hdr       = '0;
  logic [31:0]  snonce    = '0;

  logic [31:0] mw [8];
  logic [31:0] hw [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  miner_job_feeder_if if0 ();
  miner_job_feeder_if if2 ();

  miner_job_feeder #(
    .GAP_CYCLES(0),
    .TIMEOUT_CYCLES(TMO),
    .TMR_W(32)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(if0.master)
  );

  miner_job_feeder #(
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(TMO),
    .TMR_W(32)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(if2.master)
  );

  assign if0.job_valid    = job_valid && !sel;
  assign if2.job_valid    = job_valid && sel;
  assign if0.abort        = abort_i && !sel;
  assign if2.abort        = abort_i && sel;
  assign if0.sol_claim    = claim && !sel;
  assign if2.sol_claim    = claim && sel;
  assign if0.result_ready = ready && !sel;
  assign if2.result_ready = ready && sel;
  assign if0.job_midstate = mid;
  assign if2.job_midstate = mid;
  assign if0.job_header   = hdr;
  assign if2.job_header   = hdr;
  assign if0.sol_nonce    = snonce;
  assign if2.sol_nonce    = snonce;

  logic        m_jr, m_start, m_shift, m_resp, m_rv, m_rf;
  logic [31:0] m_word, m_rn;
  assign m_jr    = sel ? if2.job_ready       : if0.job_ready;
  assign m_start = sel ? if2.start_found     : if0.start_found;
  assign m_shift = sel ? if2.shift_in_enable : if0.shift_in_enable;
  assign m_word  = sel ? if2.out_word        : if0.out_word;
  assign m_resp  = sel ? if2.sol_response    : if0.sol_response;
  assign m_rv    = sel ? if2.result_valid    : if0.result_valid;
  assign m_rf    = sel ? if2.result_found    : if0.result_found;
  assign m_rn    = sel ? if2.result_nonce    : if0.result_nonce;

  // Reference: word k of the job, most significant first.
  function automatic logic [31:0] exp_word(input int k);
    return (k < 8) ? mw[k] : hw[k-8];
  endfunction

  // Reference: strobe k lands at cycle 2 + k*(gap+1) after acceptance.
  function automatic bit exp_strobe(input int c, input int gap);
    int t;
    t = c - 2;
    return (t >= 0) && (t % (gap + 1) == 0) && (t / (gap + 1) < NW);
  endfunction

  task automatic pack_job();
    for (int i = 0; i < 8; i++) mid[255-32*i -: 32] = mw[i];
    for (int i = 0; i < 16; i++) hdr[511-32*i -: 32] = hw[i];
  endtask

  task automatic set_fixed();
    for (int i = 0; i < 8; i++) mw[i] = 32'(i + 1);
    for (int i = 0; i < 16; i++) hw[i] = 32'(i + 'h11);
    pack_job();
  endtask

  task automatic set_rand();
    for (int i = 0; i < 8; i++) mw[i] = $urandom;
    for (int i = 0; i < 16; i++) hw[i] = $urandom;
    pack_job();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    job_valid = 1'b0;
    abort_i = 1'b0;
    claim = 1'b0;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      total++;
      if ({m_jr, m_start, m_shift, m_word, m_resp, m_rv, m_rf, m_rn} !==
          {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
        bad++;
        $display("FAIL reset_hold dut%0d got jr=%0b st=%0b sh=%0b w=%h rsp=%0b rv=%0b rf=%0b rn=%h exp jr=1 rest=0",
                 s, m_jr, m_start, m_shift, m_word, m_resp, m_rv, m_rf, m_rn);
      end
    end
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({m_jr, m_start, m_shift, m_resp, m_rv} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_release got=%b exp=10000",
               {m_jr, m_start, m_shift, m_resp, m_rv});
    end
  endtask

  task automatic test_stream();
    int nstr;
    logic eh;
    logic [31:0] ew;
    sel = 1'b0;
    do_reset();
    set_fixed();
    job_valid = 1'b1;
    total++;
    if (m_jr !== 1'b1) begin
      bad++;
      $display("FAIL stream_ready got=%0b exp=1", m_jr);
    end
    nstr = 0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      job_valid = 1'b0;
      eh = exp_strobe(c, 0);
      ew = eh ? exp_word(c - 2) : 32'h0;
      total++;
      if ({m_start, m_shift, m_word} !== {c == 1, eh, ew}) begin
        bad++;
        $display("FAIL stream_c%0d got st=%0b sh=%0b w=%h exp st=%0b sh=%0b w=%h",
                 c, m_start, m_shift, m_word, c == 1, eh, ew);
      end
      if (m_shift === 1'b1) nstr++;
    end
    total++;
    if (nstr != NW) begin
      bad++;
      $display("FAIL stream_count got=%0d exp=%0d", nstr, NW);
    end
    claim = 1'b1;
    snonce = 32'hDEADBEEF;
    @(negedge clk);
    claim = 1'b0;
    total++;
    if ({m_resp, m_rv} !== 2'b10) begin
      bad++;
      $display("FAIL claim_ack got rsp=%0b rv=%0b exp rsp=1 rv=0", m_resp, m_rv);
    end
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      total++;
      if ({m_rv, m_rf, m_rn, m_resp} !== {1'b1, 1'b1, 32'hDEADBEEF, 1'b0}) begin
        bad++;
        $display("FAIL claim_hold%0d got rv=%0b rf=%0b rn=%h rsp=%0b exp 1 1 deadbeef 0",
                 h, m_rv, m_rf, m_rn, m_resp);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    total++;
    if ({m_rv, m_jr} !== 2'b01) begin
      bad++;
      $display("FAIL claim_release got rv=%0b jr=%0b exp rv=0 jr=1", m_rv, m_jr);
    end
  endtask

  task automatic test_timeout();
    sel = 1'b0;
    do_reset();
    set_rand();
    job_valid = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      job_valid = 1'b0;
      if (c >= 26) begin
        total++;
        if ({m_rv, m_resp} !== {c >= 36, 1'b0}) begin
          bad++;
          $display("FAIL timeout_c%0d got rv=%0b rsp=%0b exp rv=%0b rsp=0",
                   c, m_rv, m_resp, c >= 36);
        end
      end
    end
    total++;
    if ({m_rf, m_rn} !== 33'h0) begin
      bad++;
      $display("FAIL timeout_result got rf=%0b rn=%h exp 0 0", m_rf, m_rn);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    total++;
    if ({m_rv, m_jr} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_release got rv=%0b jr=%0b exp 0 1", m_rv, m_jr);
    end
  endtask

  task automatic test_claim_priority();
    logic [31:0] nn;
    sel = 1'b0;
    do_reset();
    set_rand();
    nn = $urandom;
    job_valid = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      job_valid = 1'b0;
    end
    claim = 1'b1;
    snonce = nn;
    @(negedge clk);
    claim = 1'b0;
    total++;
    if ({m_resp, m_rv} !== 2'b10) begin
      bad++;
      $display("FAIL prio_ack got rsp=%0b rv=%0b exp 1 0", m_resp, m_rv);
    end
    @(negedge clk);
    total++;
    if ({m_rv, m_rf, m_rn} !== {1'b1, 1'b1, nn}) begin
      bad++;
      $display("FAIL prio_result got rv=%0b rf=%0b rn=%h exp 1 1 %h", m_rv, m_rf, m_rn, nn);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_gap();
    int nstr;
    int last;
    logic eh;
    logic [31:0] ew;
    logic [31:0] nn;
    sel = 1'b1;
    do_reset();
    set_rand();
    nn = $urandom;
    job_valid = 1'b1;
    nstr = 0;
    last = -1;
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      job_valid = 1'b0;
      eh = exp_strobe(c, 2);
      ew = eh ? exp_word((c - 2) / 3) : 32'h0;
      total++;
      if ({m_start, m_shift, m_word} !== {c == 1, eh, ew}) begin
        bad++;
        $display("FAIL gap_c%0d got st=%0b sh=%0b w=%h exp st=%0b sh=%0b w=%h",
                 c, m_start, m_shift, m_word, c == 1, eh, ew);
      end
      if (m_shift === 1'b1) begin
        if (last >= 0) begin
          total++;
          if (c - last != 3) begin
            bad++;
            $display("FAIL gap_spacing c=%0d got=%0d exp=3", c, c - last);
          end
        end
        last = c;
        nstr++;
      end
    end
    total++;
    if (nstr != NW) begin
      bad++;
      $display("FAIL gap_count got=%0d exp=%0d", nstr, NW);
    end
    claim = 1'b1;
    snonce = nn;
    @(negedge clk);
    claim = 1'b0;
    total++;
    if (m_resp !== 1'b1) begin
      bad++;
      $display("FAIL gap_wait_latency got rsp=%0b exp=1", m_resp);
    end
    @(negedge clk);
    total++;
    if ({m_rv, m_rf, m_rn} !== {1'b1, 1'b1, nn}) begin
      bad++;
      $display("FAIL gap_result got rv=%0b rf=%0b rn=%h exp 1 1 %h", m_rv, m_rf, m_rn, nn);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_abort();
    sel = 1'b0;
    do_reset();
    set_fixed();
    job_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      job_valid = 1'b0;
    end
    total++;
    if ({m_shift, m_word} !== {1'b1, 32'h5}) begin
      bad++;
      $display("FAIL abort_pre got sh=%0b w=%h exp 1 00000005", m_shift, m_word);
    end
    abort_i = 1'b1;
    #1;
    total++;
    if ({m_start, m_shift, m_word} !== 34'h0) begin
      bad++;
      $display("FAIL abort_drop got st=%0b sh=%0b w=%h exp 0 0 0", m_start, m_shift, m_word);
    end
    @(negedge clk);
    abort_i = 1'b0;
    total++;
    if ({m_jr, m_shift} !== 2'b10) begin
      bad++;
      $display("FAIL abort_idle got jr=%0b sh=%0b exp 1 0", m_jr, m_shift);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      total++;
      if ({m_rv, m_shift, m_start, m_resp, m_jr} !== 5'b00001) begin
        bad++;
        $display("FAIL abort_quiet%0d got=%b exp=00001", c,
                 {m_rv, m_shift, m_start, m_resp, m_jr});
      end
    end
  endtask

  task automatic test_claim_ignored();
    logic eh;
    logic [31:0] ew;
    logic [31:0] nn;
    sel = 1'b0;
    do_reset();
    set_rand();
    nn = $urandom;
    job_valid = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      job_valid = 1'b0;
      eh = exp_strobe(c, 0);
      ew = eh ? exp_word(c - 2) : 32'h0;
      total++;
      if ({m_shift, m_word, m_resp, m_rv} !== {eh, ew, c == 31, 1'b0}) begin
        bad++;
        $display("FAIL ign_c%0d got sh=%0b w=%h rsp=%0b rv=%0b exp sh=%0b w=%h rsp=%0b rv=0",
                 c, m_shift, m_word, m_resp, m_rv, eh, ew, c == 31);
      end
      claim = (c >= 12 && c <= 14) || (c == 30);
      snonce = (c == 30) ? nn : 32'h12345678;
    end
    claim = 1'b0;
    @(negedge clk);
    total++;
    if ({m_rv, m_rf, m_rn} !== {1'b1, 1'b1, nn}) begin
      bad++;
      $display("FAIL ign_result got rv=%0b rf=%0b rn=%h exp 1 1 %h", m_rv, m_rf, m_rn, nn);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    total++;
    if ({m_rv, m_rn} !== {1'b1, nn}) begin
      bad++;
      $display("FAIL report_abort got rv=%0b rn=%h exp 1 %h", m_rv, m_rn, nn);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_async_rst();
    sel = 1'b0;
    do_reset();
    set_fixed();
    job_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      job_valid = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({m_jr, m_start, m_shift, m_word, m_resp, m_rv, m_rf, m_rn} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL async_rst got jr=%0b st=%0b sh=%0b w=%h rsp=%0b rv=%0b exp jr=1 rest=0",
               m_jr, m_start, m_shift, m_word, m_resp, m_rv);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int gap, d, rd, we;
    bit fnd;
    logic eh;
    logic [31:0] ew, nn;
    for (int it = 0; it < 16; it++) begin
      sel = ($urandom_range(0, 1) == 1);
      gap = sel ? 2 : 0;
      do_reset();
      set_rand();
      d = $urandom_range(0, TMO + 2);
      rd = $urandom_range(0, 3);
      nn = $urandom;
      fnd = (d < TMO);
      we = 2 + (NW - 1) * (gap + 1) + 1;
      job_valid = 1'b1;
      total++;
      if (m_jr !== 1'b1) begin
        bad++;
        $display("FAIL rnd%0d_ready got=%0b exp=1", it, m_jr);
      end
      for (int c = 1; c < we; c++) begin
        @(negedge clk);
        job_valid = 1'b0;
        eh = exp_strobe(c, gap);
        ew = eh ? exp_word((c - 2) / (gap + 1)) : 32'h0;
        total++;
        if ({m_start, m_shift, m_word} !== {c == 1, eh, ew}) begin
          bad++;
          $display("FAIL rnd%0d_c%0d got st=%0b sh=%0b w=%h exp st=%0b sh=%0b w=%h",
                   it, c, m_start, m_shift, m_word, c == 1, eh, ew);
        end
      end
      for (int j = 0; j <= (fnd ? d : TMO - 1); j++) begin
        @(negedge clk);
        total++;
        if ({m_rv, m_resp, m_shift} !== 3'b000) begin
          bad++;
          $display("FAIL rnd%0d_wait%0d got=%b exp=000", it, j, {m_rv, m_resp, m_shift});
        end
        if (fnd && j == d) begin
          claim = 1'b1;
          snonce = nn;
        end
      end
      if (fnd) begin
        @(negedge clk);
        claim = 1'b0;
        total++;
        if ({m_resp, m_rv} !== 2'b10) begin
          bad++;
          $display("FAIL rnd%0d_ack got rsp=%0b rv=%0b exp 1 0", it, m_resp, m_rv);
        end
      end
      for (int h = 0; h <= rd; h++) begin
        @(negedge clk);
        total++;
        if ({m_rv, m_rf, m_rn, m_resp} !== {1'b1, fnd, fnd ? nn : 32'h0, 1'b0}) begin
          bad++;
          $display("FAIL rnd%0d_result got rv=%0b rf=%0b rn=%h exp 1 %0b %h",
                   it, m_rv, m_rf, m_rn, fnd, fnd ? nn : 32'h0);
        end
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      total++;
      if ({m_rv, m_jr} !== 2'b01) begin
        bad++;
        $display("FAIL rnd%0d_release got rv=%0b jr=%0b exp 0 1", it, m_rv, m_jr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_timeout();
    test_claim_priority();
    test_gap();
    test_abort();
    test_claim_ignored();
    test_async_rst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
